pluck_envelope: RTL
===================

PLUCK_ENVELOPE -- requirements
Module: pluck_envelope

Interface
REQ-001 Parameter DECAY_DIV, default 64: number of sample_en strobes per ring-decay step; legal range 1..256.
REQ-002 Parameter DECAY_SHIFT, default 4: ring-decay right-shift amount; legal range 1..7.
REQ-003 Parameter DAMP_SHIFT, default 1: damp-decay right-shift amount; legal range 1..7.
REQ-004 The block SHALL have one clock, Clk; Reset is synchronous and active-high.
REQ-005 Port: Clk  input  1  system clock; all state changes on its rising edge.
REQ-006 Port: Reset  input  1  synchronous, active-high reset.
REQ-007 Port: sample_en  input  1  one-cycle audio-rate strobe.
REQ-008 Port: pluck  input  7  per-string level vector from the note mux, with bit i for string i; it may change on any cycle.
REQ-009 Port: strike  output  7  one-cycle pulse per string on a new pluck.
REQ-010 Port: active  output  7  string i is not IDLE.
REQ-011 Port: amp  output  56  per-string amplitude, with string i at bits 8i+7..8i.
REQ-012 Port: mix  output  11  registered unsigned sum of all seven amp fields.

Function
REQ-013 The block SHALL hold a registered copy pluck_prev of the pluck vector.
REQ-014 The block SHALL define rise[i] = pluck[i] AND NOT pluck_prev[i].
REQ-015 The block SHALL define fall[i] = NOT pluck[i] AND pluck_prev[i].
REQ-016 The block SHALL keep a shared divider counter that advances only on sample_en and wraps from DECAY_DIV-1 to 0.
REQ-017 The block SHALL define tick = sample_en AND (counter == DECAY_DIV-1).
REQ-018 Each string SHALL run an independent FSM with states IDLE, RING and DAMP.
REQ-019 On rise[i], in any state: state <= RING, amp_i <= 255 and strike[i] <= 1, all on the same edge; latency is 1 cycle from pluck first high.
REQ-020 Retrigger: a rise while in RING or DAMP SHALL reload amp_i to 255 and SHALL NOT reset the shared divider.
REQ-021 rise[i] SHALL take priority over any decay step on the same cycle.
REQ-022 In RING, fall[i] SHALL move the string to DAMP with no amplitude change on that edge.
REQ-023 In RING, on tick with no rise or fall: amp_i <= amp_i - max(amp_i >> DECAY_SHIFT, 1).
REQ-024 In DAMP, on sample_en with no rise: amp_i <= amp_i - max(amp_i >> DAMP_SHIFT, 1).
REQ-025 Subtraction SHALL saturate at 0; amp_i SHALL never wrap.
REQ-026 When the decremented amp_i equals 0, state SHALL go to IDLE on the same edge.
REQ-027 In IDLE, amp_i SHALL be held at 0.
REQ-028 A level held high SHALL cause no retrigger.
REQ-029 Chord-to-chord changes SHALL be handled per bit. Example: 1111111 -> 1111110 damps string 0 only; strings 1..6 keep ringing with no strike.
REQ-030 strike[i] SHALL be 0 on every cycle except the cycle after a rise.
REQ-031 active[i] SHALL be registered and equal (state_i != IDLE).
REQ-032 mix SHALL be registered from the current amp fields, lagging amp by 1 cycle; its maximum value is 1785, so it SHALL never overflow.

Reset
REQ-033 While Reset is high, the following SHALL be cleared on the clock edge: all FSMs to IDLE, amp 0, strike 0, active 0, mix 0, pluck_prev 0, divider 0.
REQ-034 Reset SHALL override rise, tick and sample_en on the same edge.
REQ-035 A pluck bit still high when Reset deasserts SHALL produce a rise on the first post-reset edge.

Verification (DECAY_DIV=4, DECAY_SHIFT=4, DAMP_SHIFT=1)
REQ-036 Single pluck: pluck 0000010 at cycle k, held -> cycle k+1 has strike=0000010, amp1=255, active=0000010; cycle k+2 has mix=255 and strike=0.
REQ-037 Ring decay: string held, after 4 sample_en -> amp1=240; after 4 more -> amp1=225; there is no change between ticks.
REQ-038 Damp to zero: release string 1 at amp 255, then 9 sample_en -> amp1 steps through 128,64,32,16,8,4,2,1,0; active[1] drops on the edge where amp reaches 0.
REQ-039 Chord change: 1111111 then 1111110 -> string 0 enters DAMP; strike stays 0; strings 1..6 continue the RING sequence unchanged.
REQ-040 Retrigger plus simultaneous tick: rise coincident with tick while amp=100 -> amp=255 and strike=1; no decrement applied.
REQ-041 Reset mid-ring: Reset high for 1 cycle with 3 strings ringing and pluck held -> all outputs 0; the next edge gives strike on the held bits and amp=255.

Source files
------------

// File: rtl/pluck_envelope.sv
// Seven-string pluck envelope generator: per-string IDLE/RING/DAMP decay with a shared
// ring-decay divider, one-cycle strike pulses and a registered amplitude mix.
module pluck_envelope #(
    parameter int unsigned DECAY_DIV   = 64,
    parameter int unsigned DECAY_SHIFT = 4,
    parameter int unsigned DAMP_SHIFT  = 1
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        sample_en,
    input  logic [6:0]  pluck,
    output logic [6:0]  strike,
    output logic [6:0]  active,
    output logic [55:0] amp,
    output logic [10:0] mix
);

    typedef enum logic [1:0] {StIdle, StRing, StDamp} state_e;

    localparam logic [7:0] DivLast = 8'(DECAY_DIV - 1);

    // Subtract max(a >> sh, 1), saturating at zero.
    function automatic logic [7:0] decay_step(input logic [7:0] a, input logic [2:0] sh);
        logic [7:0] step;
        step = a >> sh;
        if (step == 8'd0) step = 8'd1;
        return (a > step) ? (a - step) : 8'd0;
    endfunction

    logic [6:0]  pluck_prev_q, pluck_prev_d;
    logic [6:0]  rise, fall;
    logic [6:0]  strike_q, strike_d;
    logic [6:0]  active_q, active_d;
    logic [7:0]  div_q, div_d;
    logic        tick;
    logic [10:0] mix_q, mix_d;
    state_e      state_q [7];
    state_e      state_d [7];
    logic [7:0]  amp_q [7];
    logic [7:0]  amp_d [7];

    always_comb begin
        rise         = pluck & ~pluck_prev_q;
        fall         = ~pluck & pluck_prev_q;
        pluck_prev_d = pluck;
        tick         = sample_en && (div_q == DivLast);

        div_d = div_q;
        if (sample_en) div_d = (div_q == DivLast) ? 8'd0 : div_q + 8'd1;

        mix_d = 11'd0;
        for (int i = 0; i < 7; i++) mix_d = mix_d + 11'(amp_q[i]);

        for (int i = 0; i < 7; i++) begin
            state_d[i]  = state_q[i];
            amp_d[i]    = amp_q[i];
            strike_d[i] = rise[i];
            if (rise[i]) begin
                // A new pluck wins over any decay step on the same edge.
                state_d[i] = StRing;
                amp_d[i]   = 8'd255;
            end else begin
                case (state_q[i])
                    StRing: begin
                        if (fall[i]) begin
                            state_d[i] = StDamp;
                        end else if (tick) begin
                            amp_d[i] = decay_step(amp_q[i], 3'(DECAY_SHIFT));
                            if (amp_d[i] == 8'd0) state_d[i] = StIdle;
                        end
                    end
                    StDamp: begin
                        if (sample_en) begin
                            amp_d[i] = decay_step(amp_q[i], 3'(DAMP_SHIFT));
                            if (amp_d[i] == 8'd0) state_d[i] = StIdle;
                        end
                    end
                    default: begin
                        state_d[i] = StIdle;
                        amp_d[i]   = 8'd0;
                    end
                endcase
            end
            active_d[i] = (state_d[i] != StIdle);
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            pluck_prev_q <= 7'd0;
            strike_q     <= 7'd0;
            active_q     <= 7'd0;
            div_q        <= 8'd0;
            mix_q        <= 11'd0;
            for (int i = 0; i < 7; i++) begin
                state_q[i] <= StIdle;
                amp_q[i]   <= 8'd0;
            end
        end else begin
            pluck_prev_q <= pluck_prev_d;
            strike_q     <= strike_d;
            active_q     <= active_d;
            div_q        <= div_d;
            mix_q        <= mix_d;
            for (int i = 0; i < 7; i++) begin
                state_q[i] <= state_d[i];
                amp_q[i]   <= amp_d[i];
            end
        end
    end

    always_comb begin
        amp = 56'd0;
        for (int i = 0; i < 7; i++) amp[8*i +: 8] = amp_q[i];
    end

    assign strike = strike_q;
    assign active = active_q;
    assign mix    = mix_q;

endmodule
